// File: rtl/alu_result_queue.sv
// -----------------------------------------------------------------------------
// alu_result_queue
//
// Purpose:
//   Sits after the 16-bit ALU. Each ALU result is captured with its opcode.
//   A 2-bit overflow flag is derived from the result at push time, and the
//   entry is buffered in a small first-word-fall-through queue. Both sides
//   use valid/ready handshakes, so the writeback consumer can apply
//   back-pressure without stalling the combinational ALU.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   in_valid    ALU result present this cycle
//   in_ready    queue can accept an entry (registered state only)
//   in_opcode   opcode that produced in_result
//   in_result   32-bit ALU result
//   out_valid   head entry available
//   out_ready   consumer takes the head entry this cycle
//   out_result  head entry result      (0 when out_valid = 0)
//   out_opcode  head entry opcode      (0 when out_valid = 0)
//   out_flags   head entry flags       (0 when out_valid = 0)
//   count       current occupancy, 0..DEPTH
//   err_opcode  sticky flag: opcode 3'b111 was pushed since the last reset
// -----------------------------------------------------------------------------
module alu_result_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_opcode,
    input  logic [31:0]      in_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [2:0]       out_opcode,
    output logic [1:0]       out_flags,
    output logic [CNT_W-1:0] count,
    output logic             err_opcode
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0] OP_ADD     = 3'b000;
    localparam logic [2:0] OP_MUL     = 3'b001;
    localparam logic [2:0] OP_SUB     = 3'b010;
    localparam logic [2:0] OP_ILLEGAL = 3'b111;

    logic [31:0]      r_memResult [DEPTH];
    logic [2:0]       r_memOpcode [DEPTH];
    logic [1:0]       r_memFlags  [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;
    logic             r_errOpcode;

    logic             w_push;
    logic             w_store;
    logic             w_pop;
    logic [1:0]       w_inFlags;

    // ADD reports the carry out of bit 15. SUB reports a borrow, which shows up
    // as a wrapped (negative) 32-bit result. MUL reports a product that needs
    // more than 16 bits.
    function automatic logic [1:0] calcFlags(input logic [2:0]  op,
                                             input logic [31:0] res);
        case (op)
            OP_ADD:  calcFlags = {1'b0, res[16]};
            OP_SUB:  calcFlags = {1'b0, res[31]};
            OP_MUL:  calcFlags = {(res[31:16] != 16'h0000), 1'b0};
            default: calcFlags = 2'b00;
        endcase
    endfunction

    // An illegal-opcode push still completes the handshake, but it is never
    // stored. Only w_store moves the write side.
    always_comb begin
        in_ready  = (r_count < CNT_W'(DEPTH));
        out_valid = (r_count != '0);
        w_push    = in_valid && in_ready;
        w_store   = w_push && (in_opcode != OP_ILLEGAL);
        w_pop     = out_valid && out_ready;
        w_inFlags = calcFlags(in_opcode, in_result);
    end

    // The head is gated to zero when the queue is empty, so stale storage
    // never appears on the output bus.
    always_comb begin
        out_result = '0;
        out_opcode = '0;
        out_flags  = '0;
        if (out_valid) begin
            out_result = r_memResult[r_rdPtr];
            out_opcode = r_memOpcode[r_rdPtr];
            out_flags  = r_memFlags[r_rdPtr];
        end
        count      = r_count;
        err_opcode = r_errOpcode;
    end

    // The storage array has no reset. The pointers and the count decide what
    // is valid, so old contents are unreachable after a reset.
    always_ff @(posedge clk) begin
        if (!rst && w_store) begin
            r_memResult[r_wrPtr] <= in_result;
            r_memOpcode[r_wrPtr] <= in_opcode;
            r_memFlags[r_wrPtr]  <= w_inFlags;
        end
    end

    // Pointer, count and error state. Reset wins over any push or pop in the
    // same cycle. The pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_count     <= '0;
            r_errOpcode <= 1'b0;
        end else begin
            if (w_store) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            if (w_store && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_store) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (w_push && (in_opcode == OP_ILLEGAL)) begin
                r_errOpcode <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_result_queue.sv
// -----------------------------------------------------------------------------
// tb_alu_result_queue
//
// Self-checking bench for alu_result_queue. A queue-based reference model is
// compared with the DUT on every falling edge. Directed steps follow the
// bring-up scenarios and also check literal values taken by hand from the
// flag and handshake rules.
// -----------------------------------------------------------------------------
module tb_alu_result_queue;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_opcode;
    logic [31:0]      in_result;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic [2:0]       out_opcode;
    logic [1:0]       out_flags;
    logic [CNT_W-1:0] count;
    logic             err_opcode;

    int passCount  = 0;
    int checkCount = 0;

    typedef struct packed {
        logic [31:0] res;
        logic [2:0]  op;
        logic [1:0]  flg;
    } entry_t;

    entry_t mq[$];
    logic   modelErr   = 1'b0;
    logic   modelReady = 1'b0;

    alu_result_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_result  (in_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_opcode (out_opcode),
        .out_flags  (out_flags),
        .count      (count),
        .err_opcode (err_opcode)
    );

    // 10 ns clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected overflow flags, stated in terms of what the ALU operation means.
    function automatic logic [1:0] refFlags(input logic [2:0] op, input logic [31:0] r);
        logic [1:0] f;
        f = 2'b00;
        if (op == 3'b000 && r[16])          f = 2'b01;
        if (op == 3'b010 && r[31])          f = 2'b01;
        if (op == 3'b001 && r > 32'hFFFF)   f = 2'b10;
        return f;
    endfunction

    // Reference model: a plain queue that follows the handshake rules.
    // It works from the state before the clock edge.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                mq.delete();
                modelErr   = 1'b0;
                modelReady = 1'b1;
            end else if (modelReady) begin
                bit doPop;
                bit doPush;
                doPop  = (mq.size() != 0) && out_ready;
                doPush = in_valid && (mq.size() < DEPTH);
                if (doPop) void'(mq.pop_front());
                if (doPush) begin
                    if (in_opcode == 3'b111) modelErr = 1'b1;
                    else mq.push_back('{in_result, in_opcode, refFlags(in_opcode, in_result)});
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (modelReady) begin
                entry_t exp;
                logic   expValid;
                logic   expReady;
                exp      = (mq.size() != 0) ? mq[0] : '0;
                expValid = (mq.size() != 0);
                expReady = (mq.size() < DEPTH);
                checkCount++;
                if (out_valid === expValid && in_ready === expReady &&
                    out_result === exp.res && out_opcode === exp.op &&
                    out_flags === exp.flg && int'(count) == mq.size() &&
                    err_opcode === modelErr) begin
                    passCount++;
                end else begin
                    $display("[TB] FAIL model-compare t=%0t: got v=%b r=%b res=%h op=%h f=%b cnt=%0d err=%b expected v=%b r=%b res=%h op=%h f=%b cnt=%0d err=%b",
                             $time, out_valid, in_ready, out_result, out_opcode, out_flags, count, err_opcode,
                             expValid, expReady, exp.res, exp.op, exp.flg, mq.size(), modelErr);
                end
            end
        end
    end

    // Drive one cycle of inputs, then wait until just after the edge.
    task automatic applyStimulus(input logic r, input logic v, input logic [2:0] op,
                                 input logic [31:0] res, input logic ordy);
        rst       = r;
        in_valid  = v;
        in_opcode = op;
        in_result = res;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_opcode = 3'b000; in_result = '0; out_ready = 1'b0;
        $display("[TB] start");

        // Reset state.
        applyStimulus(1, 0, 3'b000, 0, 0);
        applyStimulus(1, 0, 3'b000, 0, 0);
        applyStimulus(0, 0, 3'b000, 0, 0);
        checkOutput("reset_count", 32'(count), 0);
        checkOutput("reset_out_valid", 32'(out_valid), 0);
        checkOutput("reset_in_ready", 32'(in_ready), 1);

        // ADD with a carry out of bit 15.
        applyStimulus(0, 1, 3'b000, 32'h0001_0000, 0);
        applyStimulus(0, 0, 3'b000, 0, 0);
        checkOutput("add_valid", 32'(out_valid), 1);
        checkOutput("add_result", out_result, 32'h0001_0000);
        checkOutput("add_flags", 32'(out_flags), 32'b01);
        checkOutput("add_count", 32'(count), 1);
        applyStimulus(0, 0, 3'b000, 0, 1);
        checkOutput("add_drained", 32'(count), 0);

        // MUL, SUB and AND are queued, then popped in order.
        applyStimulus(0, 1, 3'b001, 32'h0001_FFFE, 0);
        applyStimulus(0, 1, 3'b010, 32'hFFFF_FFFF, 0);
        applyStimulus(0, 1, 3'b100, 32'h0000_00F0, 0);
        applyStimulus(0, 0, 3'b000, 0, 0);
        checkOutput("three_count", 32'(count), 3);
        checkOutput("mul_result", out_result, 32'h0001_FFFE);
        checkOutput("mul_flags", 32'(out_flags), 32'b10);
        applyStimulus(0, 0, 3'b000, 0, 1);
        applyStimulus(0, 0, 3'b000, 0, 0);
        checkOutput("sub_result", out_result, 32'hFFFF_FFFF);
        checkOutput("sub_flags", 32'(out_flags), 32'b01);
        checkOutput("sub_opcode", 32'(out_opcode), 32'h2);
        applyStimulus(0, 0, 3'b000, 0, 1);
        checkOutput("and_result", out_result, 32'h0000_00F0);
        checkOutput("and_flags", 32'(out_flags), 32'b00);
        applyStimulus(0, 0, 3'b000, 0, 1);
        checkOutput("three_drained", 32'(count), 0);

        // Fill to full. A push is dropped, and a pop at full still happens.
        for (int i = 0; i < DEPTH; i++) applyStimulus(0, 1, 3'b011, 32'hA0 + 32'(i), 0);
        checkOutput("full_in_ready", 32'(in_ready), 0);
        checkOutput("full_count", 32'(count), 4);
        applyStimulus(0, 1, 3'b011, 32'hBB, 0);
        checkOutput("full_drop_count", 32'(count), 4);
        checkOutput("full_drop_head", out_result, 32'hA0);
        applyStimulus(0, 1, 3'b011, 32'hBB, 1);
        checkOutput("full_pop_count", 32'(count), 3);
        checkOutput("full_pop_in_ready", 32'(in_ready), 1);
        checkOutput("full_pop_head", out_result, 32'hA1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 3'b000, 0, 1);
        checkOutput("full_drained", 32'(count), 0);

        // Sustained push+pop at count 2. The pointers wrap several times.
        applyStimulus(0, 1, 3'b101, 32'h100, 0);
        applyStimulus(0, 1, 3'b101, 32'h101, 0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 1, 3'b101, 32'h102 + 32'(i), 1);
            checkOutput("stream_count", 32'(count), 2);
            checkOutput("stream_head", out_result, 32'h101 + 32'(i));
        end
        applyStimulus(0, 0, 3'b000, 0, 1);
        checkOutput("stream_tail0", out_result, 32'h10B);
        applyStimulus(0, 0, 3'b000, 0, 1);
        checkOutput("stream_empty", 32'(out_valid), 0);

        // Illegal opcode: the handshake completes but nothing is stored.
        applyStimulus(0, 1, 3'b111, 32'h55, 0);
        checkOutput("illegal_err", 32'(err_opcode), 1);
        checkOutput("illegal_count", 32'(count), 0);
        applyStimulus(0, 1, 3'b000, 32'h0001_2345, 0);
        checkOutput("post_illegal_result", out_result, 32'h0001_2345);
        checkOutput("post_illegal_flags", 32'(out_flags), 32'b01);
        checkOutput("err_sticky", 32'(err_opcode), 1);
        applyStimulus(0, 1, 3'b010, 32'h5, 0);
        applyStimulus(0, 1, 3'b001, 32'h10, 0);
        checkOutput("pre_reset_count", 32'(count), 3);

        // Reset wins over a concurrent push and pop.
        applyStimulus(1, 1, 3'b000, 32'h77, 1);
        checkOutput("rst_count", 32'(count), 0);
        checkOutput("rst_out_valid", 32'(out_valid), 0);
        checkOutput("rst_out_result", out_result, 0);
        checkOutput("rst_err", 32'(err_opcode), 0);
        applyStimulus(0, 0, 3'b000, 0, 0);
        checkOutput("rst_in_ready", 32'(in_ready), 1);

        @(negedge clk);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
